// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Parametrised inter-stage pipeline register carrying a DATA_W-bit payload.
// MODE 0: stall-vector flow control with bubble insertion (stage stall bit
//         plus downstream stall bit decide load / bubble / hold).
// MODE 1: valid/ready two-entry skid buffer (main entry + one skid entry)
//         with a registered in_ready.
// flush squashes the contents (priority just below rst). A saturating
// bubble counter counts edges where out_valid was low.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   stall       stall vector (MODE 0 only)
//   flush       squash contents
//   in_valid    upstream payload valid
//   in_data     upstream payload
//   in_ready    stage can accept in_data this cycle
//   out_valid   out_data holds a live entry
//   out_data    payload to downstream (zero when out_valid is low)
//   out_ready   downstream accepts out_data (MODE 1 only)
//   bubble_cnt  saturating count of cycles with out_valid == 0
module pipe_stage_reg #(
    parameter int DATA_W    = 112,
    parameter int MODE      = 0,
    parameter int STALL_W   = 6,
    parameter int STALL_IDX = 2,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic              main_valid_reg;
    logic [DATA_W-1:0] main_data_reg;
    logic [CNT_W-1:0]  bubble_cnt_reg;

    // Inputs that one of the modes does not look at are folded here so the
    // whole port list is consumed regardless of MODE.
    logic unused_inputs;
    assign unused_inputs = ^{stall, out_ready};

    assign out_valid  = main_valid_reg;
    assign out_data   = main_data_reg;
    assign bubble_cnt = bubble_cnt_reg;

    generate
        if (MODE == 0) begin : g_stall
            logic              main_valid_next;
            logic [DATA_W-1:0] main_data_next;
            logic              stall_here;
            logic              stall_down;

            assign stall_here = stall[STALL_IDX];
            assign stall_down = stall[STALL_IDX+1];
            assign in_ready   = !stall_here;

            always_comb begin
                main_valid_next = main_valid_reg;
                main_data_next  = main_data_reg;
                if (flush) begin
                    main_valid_next = 1'b0;
                    main_data_next  = '0;
                end else if (stall_here && !stall_down) begin
                    // Downstream moves on while we are stalled: emit a bubble.
                    main_valid_next = 1'b0;
                    main_data_next  = '0;
                end else if (!stall_here) begin
                    main_valid_next = in_valid;
                    main_data_next  = in_valid ? in_data : '0;
                end
                // Both stall bits set: hold.
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid_reg <= 1'b0;
                    main_data_reg  <= '0;
                end else begin
                    main_valid_reg <= main_valid_next;
                    main_data_reg  <= main_data_next;
                end
            end
        end else begin : g_skid
            logic              skid_valid_reg;
            logic [DATA_W-1:0] skid_data_reg;
            logic              main_valid_next;
            logic [DATA_W-1:0] main_data_next;
            logic              skid_valid_next;
            logic [DATA_W-1:0] skid_data_next;
            logic              accept;
            logic              drain;

            // Registered: only depends on skid occupancy, never on out_ready.
            assign in_ready = !skid_valid_reg;
            assign accept   = in_valid && in_ready;
            assign drain    = main_valid_reg && out_ready;

            always_comb begin
                main_valid_next = main_valid_reg;
                main_data_next  = main_data_reg;
                skid_valid_next = skid_valid_reg;
                skid_data_next  = skid_data_reg;
                if (flush) begin
                    main_valid_next = 1'b0;
                    main_data_next  = '0;
                    skid_valid_next = 1'b0;
                    skid_data_next  = '0;
                end else if (!main_valid_reg) begin
                    // Skid is always empty when main is empty.
                    if (accept) begin
                        main_valid_next = 1'b1;
                        main_data_next  = in_data;
                    end
                end else if (drain) begin
                    if (skid_valid_reg) begin
                        // in_ready was low, so no beat arrives this edge.
                        main_data_next  = skid_data_reg;
                        skid_valid_next = 1'b0;
                        skid_data_next  = '0;
                    end else if (accept) begin
                        main_data_next = in_data;
                    end else begin
                        main_valid_next = 1'b0;
                        main_data_next  = '0;
                    end
                end else if (accept) begin
                    // Main stuck: the lagging in_ready lets one beat in; park it.
                    skid_valid_next = 1'b1;
                    skid_data_next  = in_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid_reg <= 1'b0;
                    main_data_reg  <= '0;
                    skid_valid_reg <= 1'b0;
                    skid_data_reg  <= '0;
                end else begin
                    main_valid_reg <= main_valid_next;
                    main_data_reg  <= main_data_next;
                    skid_valid_reg <= skid_valid_next;
                    skid_data_reg  <= skid_data_next;
                end
            end
        end
    endgenerate

    // Flush does not clear the counter; only rst does.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_reg <= '0;
        end else if (!main_valid_reg && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
            bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: three instances (MODE 0, MODE 1 skid buffer,
// MODE 0 with a 4-bit bubble counter). MODE 1 output beats are checked by a
// scoreboard queue filled at issue time and drained by a monitor process.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance 0: MODE 0 ----------------
    logic [5:0]  s0_stall;
    logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [15:0] s0_in_data, s0_out_data, s0_cnt;

    pipe_stage_reg #(.DATA_W(16), .MODE(0), .STALL_W(6), .STALL_IDX(2), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .stall(s0_stall), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_data(s0_in_data), .in_ready(s0_in_ready),
        .out_valid(s0_out_valid), .out_data(s0_out_data), .out_ready(s0_out_ready),
        .bubble_cnt(s0_cnt)
    );

    // ---------------- instance 1: MODE 1 ----------------
    logic [5:0]  s1_stall;
    logic        s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [15:0] s1_in_data, s1_out_data, s1_cnt;

    pipe_stage_reg #(.DATA_W(16), .MODE(1), .STALL_W(6), .STALL_IDX(2), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .stall(s1_stall), .flush(s1_flush),
        .in_valid(s1_in_valid), .in_data(s1_in_data), .in_ready(s1_in_ready),
        .out_valid(s1_out_valid), .out_data(s1_out_data), .out_ready(s1_out_ready),
        .bubble_cnt(s1_cnt)
    );

    // ---------------- instance 2: MODE 0, CNT_W=4 ----------------
    logic [5:0] s2_stall;
    logic       s2_flush, s2_in_valid, s2_in_ready, s2_out_valid, s2_out_ready;
    logic [7:0] s2_in_data, s2_out_data;
    logic [3:0] s2_cnt;

    pipe_stage_reg #(.DATA_W(8), .MODE(0), .STALL_W(6), .STALL_IDX(2), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .stall(s2_stall), .flush(s2_flush),
        .in_valid(s2_in_valid), .in_data(s2_in_data), .in_ready(s2_in_ready),
        .out_valid(s2_out_valid), .out_data(s2_out_data), .out_ready(s2_out_ready),
        .bubble_cnt(s2_cnt)
    );

    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every MODE 1 transfer must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && s1_out_valid && s1_out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got 0x%0h want no beat", s1_out_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (s1_out_data !== e) begin
                    bad++;
                    $display("FAIL sb_beat: got 0x%0h want 0x%0h", s1_out_data, e);
                end else begin
                    $display("ok   sb_beat: 0x%0h", s1_out_data);
                end
            end
        end
    end

    // Watchdog: the run is a fixed sequence, so this only fires on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        s0_stall = '0; s0_flush = 0; s0_in_valid = 0; s0_in_data = '0; s0_out_ready = 0;
        s1_stall = '0; s1_flush = 0; s1_in_valid = 0; s1_in_data = '0; s1_out_ready = 0;
        s2_stall = '0; s2_flush = 0; s2_in_valid = 0; s2_in_data = '0; s2_out_ready = 0;
        tick();
        tick();

        // Reset state
        chk("rst_u0_valid", 32'(s0_out_valid), 32'd0);
        chk("rst_u0_data",  32'(s0_out_data),  32'd0);
        chk("rst_u0_cnt",   32'(s0_cnt),       32'd0);
        chk("rst_u0_ready", 32'(s0_in_ready),  32'd1);
        chk("rst_u1_valid", 32'(s1_out_valid), 32'd0);
        chk("rst_u1_ready", 32'(s1_in_ready),  32'd1);
        chk("rst_u1_cnt",   32'(s1_cnt),       32'd0);

        // ---------------- MODE 0 ----------------
        rst = 1'b0;
        s0_in_valid = 1; s0_in_data = 16'h0ABC; s0_stall = 6'b000000;
        tick();                                            // E1: load
        chk("m0_load_valid", 32'(s0_out_valid), 32'd1);
        chk("m0_load_data",  32'(s0_out_data),  32'h0ABC);
        chk("m0_cnt_e1",     32'(s0_cnt),       32'd1);

        s0_stall = 6'b000100; s0_in_data = 16'h0111;
        tick();                                            // E2: bubble
        chk("m0_bub_valid", 32'(s0_out_valid), 32'd0);
        chk("m0_bub_data",  32'(s0_out_data),  32'd0);
        chk("m0_bub_ready", 32'(s0_in_ready),  32'd0);
        chk("m0_cnt_e2",    32'(s0_cnt),       32'd1);
        tick();                                            // E3: still bubble
        chk("m0_cnt_e3",    32'(s0_cnt),       32'd2);

        s0_stall = 6'b000000; s0_in_data = 16'h0ABC;
        tick();                                            // E4: load again
        chk("m0_reload", 32'(s0_out_data), 32'h0ABC);
        chk("m0_cnt_e4", 32'(s0_cnt),      32'd3);

        s0_stall = 6'b001100;
        for (int i = 0; i < 3; i++) begin                  // E5..E7: hold
            s0_in_data = 16'(16'h0200 + i);
            tick();
            chk("m0_hold_data", 32'(s0_out_data), 32'h0ABC);
        end
        chk("m0_hold_valid", 32'(s0_out_valid), 32'd1);

        s0_stall = 6'b000100; s0_flush = 1;                // flush beats stall
        tick();                                            // E8
        chk("m0_flush_valid", 32'(s0_out_valid), 32'd0);
        chk("m0_flush_data",  32'(s0_out_data),  32'd0);

        s0_flush = 0; s0_stall = 6'b000000; s0_in_valid = 0; s0_in_data = 16'h0777;
        tick();                                            // E9: load of invalid
        chk("m0_invalid_data", 32'(s0_out_data), 32'd0);
        chk("m0_cnt_e9",       32'(s0_cnt),      32'd4);
        chk("m0_u2_cnt_e9",    32'(s2_cnt),      32'd9);

        // ---------------- MODE 1: streaming ----------------
        s1_out_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            chk("m1_stream_ready", 32'(s1_in_ready), 32'd1);
            s1_in_valid = 1; s1_in_data = 16'(k);
            exp_q.push_back(16'(k));
            tick();
        end
        s1_in_valid = 0;
        tick();
        chk("m1_stream_empty", 32'(s1_out_valid), 32'd0);

        // ---------------- MODE 1: skid absorb ----------------
        s1_out_ready = 0;
        s1_in_valid = 1; s1_in_data = 16'd5; exp_q.push_back(16'd5);
        tick();                                            // main=5
        chk("m1_ready_pre6", 32'(s1_in_ready), 32'd1);
        s1_in_data = 16'd6; exp_q.push_back(16'd6);
        tick();                                            // skid=6
        chk("m1_skid_ready", 32'(s1_in_ready), 32'd0);
        chk("m1_skid_main",  32'(s1_out_data), 32'd5);
        s1_in_valid = 0; s1_out_ready = 1;
        tick();                                            // main<-skid
        chk("m1_refill_ready", 32'(s1_in_ready), 32'd1);
        chk("m1_refill_data",  32'(s1_out_data), 32'd6);
        tick();                                            // drained
        chk("m1_drain_valid", 32'(s1_out_valid), 32'd0);
        chk("m1_drain_data",  32'(s1_out_data),  32'd0);

        // ---------------- MODE 1: flush with both entries full ----------------
        s1_out_ready = 0;
        s1_in_valid = 1; s1_in_data = 16'd5;
        tick();
        s1_in_data = 16'd6;
        tick();
        s1_in_valid = 0;
        chk("m1_full_ready", 32'(s1_in_ready), 32'd0);
        s1_flush = 1;
        tick();
        s1_flush = 0;
        chk("m1_flush_valid", 32'(s1_out_valid), 32'd0);
        chk("m1_flush_data",  32'(s1_out_data),  32'd0);
        chk("m1_flush_ready", 32'(s1_in_ready),  32'd1);
        s1_out_ready = 1;
        tick();
        tick();
        chk("m1_post_flush_valid", 32'(s1_out_valid), 32'd0);
        chk("m1_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- counter saturation and reset ----------------
        chk("u2_cnt_sat",   32'(s2_cnt),       32'd15);
        chk("u2_valid_low", 32'(s2_out_valid), 32'd0);
        rst = 1; s0_flush = 1;                             // rst wins over flush
        tick();
        rst = 0; s0_flush = 0;
        chk("rst2_u2_cnt", 32'(s2_cnt), 32'd0);
        chk("rst2_u0_cnt", 32'(s0_cnt), 32'd0);
        chk("rst2_u1_cnt", 32'(s1_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
